// File: rtl/stream_mux_pkg.sv
// stream_mux shared definitions
// FSM encoding and select-width helper
package stream_mux_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rotating-priority encoder for stream_mux
// finds first set request at or after start, wrapping
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_BITS = 4
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_BITS-1:0] start,
  output logic                found,
  output logic [SEL_BITS-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      j = (int'(start) + k) % CHANNELS;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SEL_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered stream mux with packet lock
// explicit-select or round-robin arbitration
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  parameter int SEL_BITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rr_mode,
  input  logic [SEL_BITS-1:0]       select,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_BITS-1:0]       out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SLOTS = 1 << SEL_BITS;

  if (SEL_BITS < clog2(CHANNELS)) begin : g_bad_sel
    $error("stream_mux: SEL_BITS too small for CHANNELS");
  end

  state_t              state;
  logic [SEL_BITS-1:0] grant;
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] cand;
  logic [SEL_BITS-1:0] nxt_ptr;
  logic [SEL_BITS-1:0] pick_idx;
  logic                pick_found;
  logic                cand_ok;
  logic                load;
  logic                accept;

  // padded views: out-of-range IDs read as idle channels
  logic [SLOTS-1:0] vpad;
  logic [SLOTS-1:0] lpad;
  logic [WIDTH-1:0] dpad [SLOTS];

  assign vpad = SLOTS'(in_valid);
  assign lpad = SLOTS'(in_last);

  for (genvar i = 0; i < SLOTS; i++) begin : g_pad
    if (i < CHANNELS) begin : g_ch
      assign dpad[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_nc
      assign dpad[i] = '0;
    end
  end

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_BITS (SEL_BITS)
  ) u_pick (
    .req   (in_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    unique case (1'b1)
      (state == ST_HOLD): begin
        cand    = grant;
        cand_ok = vpad[grant];
      end
      (state == ST_ARB && rr_mode): begin
        cand    = pick_idx;
        cand_ok = pick_found;
      end
      default: begin
        cand    = select;
        cand_ok = vpad[select];
      end
    endcase
  end

  assign load    = ~out_valid | out_ready;
  assign accept  = load & cand_ok & ~reset;
  assign nxt_ptr = (cand == SEL_BITS'(CHANNELS - 1))
                 ? '0 : cand + 1'b1;

  assign in_ready = accept
                  ? ({{(CHANNELS-1){1'b0}}, 1'b1} << cand)
                  : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_ARB;
      grant       <= '0;
      rr_ptr      <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      out_data    <= dpad[cand];
      out_last    <= lpad[cand];
      out_channel <= cand;
      out_valid   <= 1'b1;
      if (lpad[cand]) begin
        state  <= ST_ARB;
        rr_ptr <= nxt_ptr;
      end else if (state == ST_ARB) begin
        grant <= cand;
        state <= ST_HOLD;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// directed self-checking bench for stream_mux
// 16-channel main instance plus 5-channel boundary instance
module tb_stream_mux;
  import stream_mux_pkg::*;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic          rr_mode;
  logic [3:0]    select;
  logic [511:0]  in_data;
  logic [15:0]   in_valid;
  logic [15:0]   in_last;
  logic [15:0]   in_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic [3:0]    out_channel;
  logic          out_valid;
  logic          out_ready;

  logic          b_rr_mode;
  logic [2:0]    b_select;
  logic [159:0]  b_in_data;
  logic [4:0]    b_in_valid;
  logic [4:0]    b_in_last;
  logic [4:0]    b_in_ready;
  logic [31:0]   b_out_data;
  logic          b_out_last;
  logic [2:0]    b_out_channel;
  logic          b_out_valid;
  logic          b_out_ready;

  always #5 clock = ~clock;

  stream_mux #(.WIDTH(32), .CHANNELS(16), .SEL_BITS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .rr_mode     (rr_mode),
    .select      (select),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  stream_mux #(.WIDTH(32), .CHANNELS(5), .SEL_BITS(3)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .rr_mode     (b_rr_mode),
    .select      (b_select),
    .in_data     (b_in_data),
    .in_valid    (b_in_valid),
    .in_last     (b_in_last),
    .in_ready    (b_in_ready),
    .out_data    (b_out_data),
    .out_last    (b_out_last),
    .out_channel (b_out_channel),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input int ch, input logic [31:0] d,
                     input logic l);
    in_data[ch*32 +: 32] = d;
    in_last[ch] = l;
    in_valid[ch] = 1'b1;
  endtask

  initial begin
    rr_mode     = 1'b0;
    select      = 4'd0;
    in_data     = '0;
    in_valid    = 16'hffff;
    in_last     = '0;
    out_ready   = 1'b1;
    b_rr_mode   = 1'b0;
    b_select    = 3'd0;
    b_in_data   = '0;
    b_in_valid  = '0;
    b_in_last   = '0;
    b_out_ready = 1'b1;

    // reset values
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_last", 64'(out_last), 64'h0);
    chk("rst_out_channel", 64'(out_channel), 64'h0);
    chk("rst_state", 64'(dut.state), 64'(ST_ARB));
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    in_valid = '0;
    reset = 1'b0;
    tick();

    // boundary instance: out-of-range select
    b_select   = 3'd6;
    b_in_valid = 5'b11111;
    b_in_last  = 5'b11111;
    settle();
    chk("b_sel6_ready", 64'(b_in_ready), 64'h0);
    tick();
    chk("b_sel6_valid", 64'(b_out_valid), 64'h0);
    // single beat on ch3 -> rr_ptr 4
    b_select   = 3'd3;
    b_in_valid = 5'b01000;
    b_in_data[3*32 +: 32] = 32'hb3;
    settle();
    chk("b_sel3_ready", 64'(b_in_ready), 64'h08);
    tick();
    chk("b_sel3_data", 64'(b_out_data), 64'hb3);
    chk("b_ptr4", 64'(dut_b.rr_ptr), 64'h4);
    // rr wrap to ch0
    b_rr_mode  = 1'b1;
    b_in_valid = 5'b00001;
    b_in_data[31:0] = 32'hb0;
    settle();
    chk("b_wrap_ready", 64'(b_in_ready), 64'h01);
    tick();
    chk("b_wrap_chan", 64'(b_out_channel), 64'h0);
    chk("b_wrap_data", 64'(b_out_data), 64'hb0);
    chk("b_wrap_ptr", 64'(dut_b.rr_ptr), 64'h1);
    // last beat on ch4 wraps rr_ptr to 0
    b_rr_mode  = 1'b0;
    b_select   = 3'd4;
    b_in_valid = 5'b10000;
    tick();
    chk("b_ch4_chan", 64'(b_out_channel), 64'h4);
    chk("b_ch4_ptr", 64'(dut_b.rr_ptr), 64'h0);
    b_in_valid = '0;

    // select mode, single beat on ch5
    select = 4'd5;
    put(5, 32'ha5a5_0005, 1'b1);
    settle();
    chk("sel5_ready", 64'(in_ready), 64'h0020);
    tick();
    chk("sel5_data", 64'(out_data), 64'ha5a5_0005);
    chk("sel5_chan", 64'(out_channel), 64'h5);
    chk("sel5_last", 64'(out_last), 64'h1);
    chk("sel5_valid", 64'(out_valid), 64'h1);
    chk("sel5_ptr", 64'(dut.rr_ptr), 64'h6);
    chk("sel5_state", 64'(dut.state), 64'(ST_ARB));
    in_valid = '0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'h0);

    // packet lock on ch3, select moves to 7
    select = 4'd3;
    put(3, 32'h301, 1'b0);
    put(7, 32'h701, 1'b1);
    settle();
    chk("lock_b1_ready", 64'(in_ready), 64'h0008);
    tick();
    chk("lock_b1_data", 64'(out_data), 64'h301);
    chk("lock_state", 64'(dut.state), 64'(ST_HOLD));
    select = 4'd7;
    put(3, 32'h302, 1'b0);
    settle();
    chk("lock_b2_ready", 64'(in_ready), 64'h0008);
    tick();
    chk("lock_b2_data", 64'(out_data), 64'h302);
    chk("lock_b2_chan", 64'(out_channel), 64'h3);
    put(3, 32'h303, 1'b1);
    tick();
    chk("lock_b3_data", 64'(out_data), 64'h303);
    chk("lock_b3_last", 64'(out_last), 64'h1);
    chk("lock_ptr", 64'(dut.rr_ptr), 64'h4);
    chk("lock_end_state", 64'(dut.state), 64'(ST_ARB));
    in_valid[3] = 1'b0;
    settle();
    chk("ch7_ready", 64'(in_ready), 64'h0080);
    tick();
    chk("ch7_data", 64'(out_data), 64'h701);
    chk("ch7_chan", 64'(out_channel), 64'h7);

    // backpressure with a beat registered
    out_ready = 1'b0;
    put(7, 32'h702, 1'b1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("bp_ready", 64'(in_ready), 64'h0);
      tick();
      chk("bp_data", 64'(out_data), 64'h701);
      chk("bp_valid", 64'(out_valid), 64'h1);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_ready", 64'(in_ready), 64'h0080);
    tick();
    chk("bp_new_data", 64'(out_data), 64'h702);
    chk("bp_new_valid", 64'(out_valid), 64'h1);
    in_valid = '0;
    tick();

    // reset mid-packet
    out_ready = 1'b0;
    select = 4'd1;
    put(1, 32'h101, 1'b0);
    tick();
    chk("mid_state", 64'(dut.state), 64'(ST_HOLD));
    chk("mid_valid", 64'(out_valid), 64'h1);
    reset = 1'b1;
    settle();
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_state", 64'(dut.state), 64'(ST_ARB));
    chk("mid_rst_ptr", 64'(dut.rr_ptr), 64'h0);
    out_ready = 1'b1;
    put(1, 32'h111, 1'b1);
    tick();
    chk("fresh_data", 64'(out_data), 64'h111);
    chk("fresh_chan", 64'(out_channel), 64'h1);
    chk("fresh_ptr", 64'(dut.rr_ptr), 64'h2);
    in_valid = '0;

    // round robin over ch2, ch9, ch14 from rr_ptr 2
    rr_mode = 1'b1;
    select  = 4'd15;
    put(2, 32'h2, 1'b1);
    put(9, 32'h9, 1'b1);
    put(14, 32'he, 1'b1);
    for (int c = 0; c < 6; c++) begin
      logic [3:0] exp_ch;
      case (c % 3)
        0: exp_ch = 4'd2;
        1: exp_ch = 4'd9;
        default: exp_ch = 4'd14;
      endcase
      tick();
      chk("rr_chan", 64'(out_channel), 64'(exp_ch));
      chk("rr_data", 64'(out_data), 64'(exp_ch));
      chk("rr_valid", 64'(out_valid), 64'h1);
    end
    in_valid = '0;
    tick();
    chk("rr_idle", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
